// File: rtl/axi_slv_pkg.sv
// axi_slv_pkg: shared constants, burst context type and address-step helper
// for the axi_slave_sram responder.
package axi_slv_pkg;

   localparam int ID_W = 4;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_READ = 1'b1;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   // Everything captured from an AR or AW handshake that the burst needs later
   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     addr;
      logic [7:0]      len;
      logic [2:0]      size;
      logic [1:0]      burst;
   } burst_ctx_t;

   // Address of the next beat; WRAP is deliberately handled like INCR
   function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  burst);
      logic [31:0] nxt;
      case (burst)
         BURST_FIXED: nxt = addr;
         BURST_INCR,
         BURST_WRAP:  nxt = addr + (32'd1 << size);
         default:     nxt = addr + (32'd1 << size);
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/axi_slave_sram_if.sv
// axi_slave_sram_if: AXI3 read/write channel bundle between the initiator
// (master modport) and the SRAM responder (slave modport).
interface axi_slave_sram_if;
   import axi_slv_pkg::*;

   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic [1:0]      arlock;
   logic [3:0]      arcache;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;

   logic [ID_W-1:0] rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   logic [ID_W-1:0] awid;
   logic [31:0]     awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic [1:0]      awlock;
   logic [3:0]      awcache;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;

   logic [ID_W-1:0] wid;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;

   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/sram_sp_1rw.sv
// sram_sp_1rw: single-port 32-bit SRAM with byte write enables and a
// registered read port. The read register only changes on a read access.
module sram_sp_1rw #(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [0:(1<<AW)-1];
   logic [31:0] r_q;

   // One access per cycle: byte-masked write, or read into the output register
   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int b = 0; b < 4; b++) begin
               if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end else begin
            r_q <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/axi_slave_sram.sv
// axi_slave_sram: AXI3 responder serving INCR/FIXED bursts from one
// single-port SRAM, with read and write channels sharing the port through
// a fairness arbiter. Define AXI_SLV_RAND_STALL_EN for LFSR back-pressure.
module axi_slave_sram
   import axi_slv_pkg::*;
#(
   parameter int          MEM_AW     = 16,
   parameter logic [15:0] STALL_SEED = 16'hACE1
) (
   input logic             aclk,
   input logic             aresetn,
   axi_slave_sram_if.slave axi
);

   logic            r_active;
   logic            w_stall;
   logic [0:0]      r_rstate;
   burst_ctx_t      r_rctx;
   logic [7:0]      r_rbeat;
   logic            r_rdone, r_rinfl, r_rinfl_oor, r_rinfl_last;
   logic            r_rvalid, r_rlast;
   logic [31:0]     r_rdata;
   logic [1:0]      r_rresp;
   logic [ID_W-1:0] r_rid;
   logic [1:0]      r_wstate;
   burst_ctx_t      r_wctx;
   logic [7:0]      r_wbeat;
   logic            r_wdecerr, r_bvalid;
   logic [1:0]      r_bresp;
   logic [ID_W-1:0] r_bid;
   logic            r_last_rd;
   logic            w_rd_oor, w_wr_oor, w_rd_req, w_wr_req, w_rd_gnt, w_wr_gnt;
   logic            w_r_hs, w_arready, w_awready, w_wr_final;
   logic            w_sram_en;
   logic [MEM_AW-1:0] w_sram_addr;
   logic [31:0]     w_sram_q;
   logic            w_unused;

`ifdef AXI_SLV_RAND_STALL_EN
   logic [15:0] r_lfsr;

   // Free-running Galois LFSR; bit 0 marks a stall cycle
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_lfsr <= STALL_SEED;
      else          r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   end
   assign w_stall = r_lfsr[0];
`else
   logic w_seed_unused;
   assign w_stall       = 1'b0;
   assign w_seed_unused = ^STALL_SEED;
`endif

   assign w_unused = ^{axi.arlock, axi.arcache, axi.arprot,
                       axi.awlock, axi.awcache, axi.awprot, axi.wid};

   assign w_rd_oor   = |r_rctx.addr[31:MEM_AW+2];
   assign w_wr_oor   = |r_wctx.addr[31:MEM_AW+2];
   assign w_r_hs     = r_rvalid & axi.rready;
   assign w_wr_final = axi.wlast | (r_wbeat == r_wctx.len);

   assign w_rd_req = (r_rstate == R_READ) & ~r_rdone & ~r_rinfl
                   & (~r_rvalid | axi.rready) & ~w_stall;
   assign w_wr_req = (r_wstate == W_DATA) & axi.wvalid & ~w_stall;
   assign w_rd_gnt = w_rd_req & (~w_wr_req | ~r_last_rd);
   assign w_wr_gnt = w_wr_req & (~w_rd_req |  r_last_rd);

   assign w_arready = r_active & (r_rstate == R_IDLE) & ~w_stall;
   assign w_awready = r_active & (r_wstate == W_IDLE) & ~w_stall;

   assign axi.arready = w_arready;
   assign axi.awready = w_awready;
   assign axi.wready  = w_wr_gnt;
   assign axi.rvalid  = r_rvalid;
   assign axi.rdata   = r_rdata;
   assign axi.rresp   = r_rresp;
   assign axi.rlast   = r_rlast;
   assign axi.rid     = r_rid;
   assign axi.bvalid  = r_bvalid;
   assign axi.bresp   = r_bresp;
   assign axi.bid     = r_bid;

   assign w_sram_en   = (w_rd_gnt & ~w_rd_oor) | (w_wr_gnt & ~w_wr_oor);
   assign w_sram_addr = w_wr_gnt ? r_wctx.addr[MEM_AW+1:2] : r_rctx.addr[MEM_AW+1:2];

   sram_sp_1rw #(.AW(MEM_AW)) u_sram (
      .clk     (aclk),
      .i_en    (w_sram_en),
      .i_we    (w_wr_gnt),
      .i_be    (axi.wstrb),
      .i_addr  (w_sram_addr),
      .i_wdata (axi.wdata),
      .o_rdata (w_sram_q)
   );

   // Readies stay low until the first clock after reset release; the arbiter
   // remembers the last winner so a conflicting requester gets the next slot
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_active  <= 1'b0;
         r_last_rd <= 1'b1;
      end else begin
         r_active <= 1'b1;
         if (w_rd_gnt)      r_last_rd <= 1'b1;
         else if (w_wr_gnt) r_last_rd <= 1'b0;
      end
   end

   // Read burst sequencing: capture AR, issue one SRAM read per beat
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rstate     <= R_IDLE;
         r_rctx       <= '0;
         r_rbeat      <= '0;
         r_rdone      <= 1'b0;
         r_rinfl      <= 1'b0;
         r_rinfl_oor  <= 1'b0;
         r_rinfl_last <= 1'b0;
      end else begin
         r_rinfl      <= w_rd_gnt;
         r_rinfl_oor  <= w_rd_oor;
         r_rinfl_last <= (r_rbeat == r_rctx.len);
         case (r_rstate)
            R_IDLE: begin
               if (axi.arvalid && w_arready) begin
                  r_rctx   <= '{id: axi.arid, addr: axi.araddr, len: axi.arlen,
                                size: axi.arsize, burst: axi.arburst};
                  r_rbeat  <= '0;
                  r_rdone  <= 1'b0;
                  r_rstate <= R_READ;
               end
            end
            default: begin
               if (w_rd_gnt) begin
                  r_rctx.addr <= axi_next_addr(r_rctx.addr, r_rctx.size, r_rctx.burst);
                  r_rbeat     <= r_rbeat + 8'd1;
                  r_rdone     <= (r_rbeat == r_rctx.len);
               end
               if (w_r_hs && r_rlast) r_rstate <= R_IDLE;
            end
         endcase
      end
   end

   // Read data register: loaded the cycle after an SRAM read, held until taken
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
         r_rlast  <= 1'b0;
         r_rid    <= '0;
      end else if (r_rinfl) begin
         r_rvalid <= 1'b1;
         r_rdata  <= r_rinfl_oor ? 32'h0 : w_sram_q;
         r_rresp  <= r_rinfl_oor ? RESP_DECERR : RESP_OKAY;
         r_rlast  <= r_rinfl_last;
         r_rid    <= r_rctx.id;
      end else if (w_r_hs) begin
         r_rvalid <= 1'b0;
      end
   end

   // Write burst sequencing: capture AW, accept granted W beats, then respond
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wstate  <= W_IDLE;
         r_wctx    <= '0;
         r_wbeat   <= '0;
         r_wdecerr <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_bid     <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (axi.awvalid && w_awready) begin
                  r_wctx    <= '{id: axi.awid, addr: axi.awaddr, len: axi.awlen,
                                 size: axi.awsize, burst: axi.awburst};
                  r_wbeat   <= '0;
                  r_wdecerr <= 1'b0;
                  r_wstate  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_wr_gnt) begin
                  r_wctx.addr <= axi_next_addr(r_wctx.addr, r_wctx.size, r_wctx.burst);
                  r_wbeat     <= r_wbeat + 8'd1;
                  if (w_wr_oor) r_wdecerr <= 1'b1;
                  if (w_wr_final) begin
                     r_bvalid <= 1'b1;
                     r_bresp  <= (w_wr_oor | r_wdecerr) ? RESP_DECERR : RESP_OKAY;
                     r_bid    <= r_wctx.id;
                     r_wstate <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (axi.bready) begin
                  r_bvalid <= 1'b0;
                  r_wstate <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_slave_sram.sv
// tb_axi_slave_sram: directed bench for axi_slave_sram with a read-beat and
// write-response scoreboard. Inputs change on the falling edge and outputs
// are sampled 1 time unit later.
module tb_axi_slave_sram;
   import axi_slv_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rBeat_t;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } bResp_t;

   logic   aclk    = 1'b0;
   logic   aresetn = 1'b0;
   int     checks  = 0;
   int     errors  = 0;
   int     cycleCount = 0;
   rBeat_t rExp[$];
   bResp_t bExp[$];

   axi_slave_sram_if bus();

   axi_slave_sram #(.MEM_AW(16), .STALL_SEED(16'hACE1)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .axi     (bus)
   );

   // 10-unit clock and a cycle counter used for latency measurements
   always #5 aclk = ~aclk;
   always @(posedge aclk) cycleCount <= cycleCount + 1;

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic void expectRead(input logic [3:0] id, input logic [31:0] base,
                                      input int len, input logic [1:0] resp, input bit step);
      for (int i = 0; i <= len; i++) begin
         rBeat_t e;
         e.data = step ? base + 32'(i) : base;
         e.resp = resp;
         e.last = (i == len);
         e.id   = id;
         rExp.push_back(e);
      end
   endfunction

   task automatic sendAr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, output int hsCycle);
      int cnt = 0;
      @(negedge aclk);
      bus.arid = id; bus.araddr = addr; bus.arlen = len;
      bus.arsize = 3'd2; bus.arburst = burst; bus.arvalid = 1'b1;
      #1;
      while (!bus.arready && cnt < 200) begin @(negedge aclk); #1; cnt++; end
      checkOutput("ar_accept", 32'(cnt < 200), 1);
      @(posedge aclk); #1;
      hsCycle = cycleCount;
      bus.arvalid = 1'b0;
   endtask

   task automatic sendAw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
      int cnt = 0;
      @(negedge aclk);
      bus.awid = id; bus.awaddr = addr; bus.awlen = len;
      bus.awsize = 3'd2; bus.awburst = burst; bus.awvalid = 1'b1;
      #1;
      while (!bus.awready && cnt < 200) begin @(negedge aclk); #1; cnt++; end
      checkOutput("aw_accept", 32'(cnt < 200), 1);
      @(posedge aclk); #1;
      bus.awvalid = 1'b0;
   endtask

   task automatic sendW(input logic [31:0] base, input int len, input logic [3:0] strb);
      for (int i = 0; i <= len; i++) begin
         int cnt = 0;
         @(negedge aclk);
         bus.wvalid = 1'b1; bus.wdata = base + 32'(i); bus.wstrb = strb; bus.wlast = (i == len);
         #1;
         while (!bus.wready && cnt < 200) begin @(negedge aclk); #1; cnt++; end
         checkOutput("w_accept", 32'(cnt < 200), 1);
      end
      @(negedge aclk);
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
   endtask

   // Full write transaction: AW, data beats, then the B response
   task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input int len,
                                input logic [1:0] burst, input logic [31:0] base,
                                input logic [3:0] strb, input logic [1:0] expResp);
      int cnt = 0;
      bResp_t e;
      bExp.push_back('{id: id, resp: expResp});
      sendAw(id, addr, 8'(len), burst);
      sendW(base, len, strb);
      bus.bready = 1'b1;
      #1;
      while (!bus.bvalid && cnt < 200) begin @(negedge aclk); #1; cnt++; end
      checkOutput("b_valid", 32'(cnt < 200), 1);
      e = bExp.pop_front();
      checkOutput("bid", 32'(bus.bid), 32'(e.id));
      checkOutput("bresp", 32'(bus.bresp), 32'(e.resp));
      @(negedge aclk);
      bus.bready = 1'b0;
   endtask

   // Collect n beats against the scoreboard, optionally dropping rready for
   // stallCycles cycles once stallAfter beats have been taken
   task automatic collectR(input int n, input int stallAfter, input int stallCycles,
                           input int hsCycle, input bit checkLat);
      int got = 0, cnt = 0, stallLeft = stallCycles;
      bit first = 1'b1, sawHeld = 1'b0;
      rBeat_t e;
      while (got < n && cnt < 500) begin
         @(negedge aclk);
         if (got == stallAfter && stallLeft > 0) begin
            bus.rready = 1'b0;
            stallLeft--;
         end else begin
            bus.rready = 1'b1;
         end
         #1;
         if (!bus.rready && sawHeld) checkOutput("r_hold_valid", 32'(bus.rvalid), 1);
         if (bus.rvalid) begin
            if (first && checkLat) checkOutput("r_latency", 32'(cycleCount - hsCycle), 2);
            first = 1'b0;
            if (!bus.rready) sawHeld = 1'b1;
            if (rExp.size() == 0) begin
               checkOutput("r_unexpected_beat", 32'(rExp.size()), 1);
            end else begin
               e = rExp[0];
               checkOutput("rdata", bus.rdata, e.data);
               checkOutput("rresp", 32'(bus.rresp), 32'(e.resp));
               checkOutput("rlast", 32'(bus.rlast), 32'(e.last));
               checkOutput("rid", 32'(bus.rid), 32'(e.id));
               if (bus.rready) begin
                  void'(rExp.pop_front());
                  got++;
               end
            end
         end
         cnt++;
      end
      checkOutput("r_beats_done", 32'(got), 32'(n));
      @(negedge aclk);
      bus.rready = 1'b0;
   endtask

   task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int stallAfter,
                            input int stallCycles, input bit checkLat);
      int hs;
      sendAr(id, addr, 8'(len), burst, hs);
      collectR(len + 1, stallAfter, stallCycles, hs, checkLat);
   endtask

   initial begin
      int hs, cnt;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
      bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
      bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;

      // Reset values
      #12;
      checkOutput("rst_readies", 32'({bus.arready, bus.awready, bus.wready}), 0);
      checkOutput("rst_valids", 32'({bus.rvalid, bus.bvalid}), 0);
      checkOutput("rst_rdata", bus.rdata, 0);
      checkOutput("rst_rfields", 32'({bus.rid, bus.rresp, bus.rlast}), 0);
      checkOutput("rst_bfields", 32'({bus.bid, bus.bresp}), 0);
      @(negedge aclk);
      aresetn = 1'b1;

      // Single write then single read with latency check
      applyStimulus(4'd3, 32'h100, 0, BURST_INCR, 32'hDEADBEEF, 4'hF, RESP_OKAY);
      expectRead(4'd6, 32'hDEADBEEF, 0, RESP_OKAY, 1'b1);
      readBurst(4'd6, 32'h100, 0, BURST_INCR, -1, 0, 1'b1);

      // Four-beat INCR write and read-back
      applyStimulus(4'd1, 32'h200, 3, BURST_INCR, 32'h1, 4'hF, RESP_OKAY);
      expectRead(4'd5, 32'h1, 3, RESP_OKAY, 1'b1);
      readBurst(4'd5, 32'h200, 3, BURST_INCR, -1, 0, 1'b0);

      // Byte strobes merge into the existing word
      applyStimulus(4'd2, 32'h300, 0, BURST_INCR, 32'hFFFFFFFF, 4'hF, RESP_OKAY);
      applyStimulus(4'd2, 32'h300, 0, BURST_INCR, 32'h0000AAAA, 4'b0011, RESP_OKAY);
      expectRead(4'd2, 32'hFFFFAAAA, 0, RESP_OKAY, 1'b1);
      readBurst(4'd2, 32'h300, 0, BURST_INCR, -1, 0, 1'b0);

      // Back-pressure for 5 cycles after the first beat
      expectRead(4'd7, 32'h1, 3, RESP_OKAY, 1'b1);
      readBurst(4'd7, 32'h200, 3, BURST_INCR, 1, 5, 1'b0);

      // Concurrent read and write bursts contending for the port
      expectRead(4'd2, 32'h1, 3, RESP_OKAY, 1'b1);
      fork
         applyStimulus(4'd4, 32'h400, 3, BURST_INCR, 32'h40, 4'hF, RESP_OKAY);
         readBurst(4'd2, 32'h200, 3, BURST_INCR, -1, 0, 1'b0);
      join
      expectRead(4'd4, 32'h40, 3, RESP_OKAY, 1'b1);
      readBurst(4'd4, 32'h400, 3, BURST_INCR, -1, 0, 1'b0);

      // FIXED bursts stay on one word
      applyStimulus(4'd8, 32'h500, 1, BURST_FIXED, 32'hA0, 4'hF, RESP_OKAY);
      expectRead(4'd8, 32'hA1, 1, RESP_OKAY, 1'b0);
      readBurst(4'd8, 32'h500, 1, BURST_FIXED, -1, 0, 1'b0);

      // Out-of-range accesses: DECERR, zero data, aliased word untouched
      applyStimulus(4'd0, 32'h0, 0, BURST_INCR, 32'h12345678, 4'hF, RESP_OKAY);
      applyStimulus(4'd9, 32'h0004_0000, 0, BURST_INCR, 32'h00000BAD, 4'hF, RESP_DECERR);
      expectRead(4'd9, 32'h0, 0, RESP_DECERR, 1'b0);
      readBurst(4'd9, 32'h0004_0000, 0, BURST_INCR, -1, 0, 1'b0);
      expectRead(4'd1, 32'h12345678, 0, RESP_OKAY, 1'b1);
      readBurst(4'd1, 32'h0, 0, BURST_INCR, -1, 0, 1'b0);

      // Reset while a write response and a read beat are pending
      sendAw(4'd10, 32'h600, 8'd1, BURST_INCR);
      sendW(32'h60, 1, 4'hF);
      cnt = 0;
      #1;
      while (!bus.bvalid && cnt < 200) begin @(negedge aclk); #1; cnt++; end
      checkOutput("pre_rst_bvalid", 32'(bus.bvalid), 1);
      sendAr(4'd11, 32'h200, 8'd3, BURST_INCR, hs);
      cnt = 0;
      while (!bus.rvalid && cnt < 200) begin @(negedge aclk); #1; cnt++; end
      checkOutput("pre_rst_rvalid", 32'(bus.rvalid), 1);
      @(negedge aclk); #2;
      aresetn = 1'b0;
      #1;
      checkOutput("mid_rst_valids", 32'({bus.rvalid, bus.bvalid}), 0);
      checkOutput("mid_rst_readies", 32'({bus.arready, bus.awready, bus.wready}), 0);
      checkOutput("mid_rst_rdata", bus.rdata, 0);
      @(negedge aclk);
      aresetn = 1'b1;

      // Memory survives reset
      expectRead(4'd12, 32'h60, 1, RESP_OKAY, 1'b1);
      readBurst(4'd12, 32'h600, 1, BURST_INCR, -1, 0, 1'b0);
      expectRead(4'd13, 32'hDEADBEEF, 0, RESP_OKAY, 1'b1);
      readBurst(4'd13, 32'h100, 0, BURST_INCR, -1, 0, 1'b0);

      checkOutput("r_scoreboard_empty", 32'(rExp.size()), 0);
      checkOutput("b_scoreboard_empty", 32'(bExp.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
